// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared FSM encoding and index-width helper for the APB bridge
//
// Purpose : types and helpers used by apb_multi_slave_bridge and apb_addr_decoder.
// Contents: state_t  - bridge FSM states (IDLE/SETUP/ACCESS)
//           idx_width - slave-index width, never less than one bit
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  function automatic int idx_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational address-to-slave decoder
//
// Purpose : splits the CPU address into a slave index and a validity flag.
// Ports   : MADDR     in  ADDR_SIZE  request address
//           idx       out IDX_W      slave index (low bits of the region number)
//           idx_valid out 1          region number addresses an existing slave
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_SIZE   = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int REGION_BITS = 12,
  parameter int IDX_W       = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_SIZE-1:0] MADDR,
  output logic [IDX_W-1:0]     idx,
  output logic                 idx_valid
);

  localparam int RW = ADDR_SIZE - REGION_BITS;

  logic [RW-1:0] region;

  // The whole upper address is compared, not just the index bits, so an
  // address above the last window cannot alias onto a real slave.
  assign region    = MADDR[ADDR_SIZE-1:REGION_BITS];
  assign idx       = region[IDX_W-1:0];
  assign idx_valid = (region < RW'(NUM_SLAVES));

endmodule

// File: rtl/apb_multi_slave_bridge.sv
// rtl/apb_multi_slave_bridge.sv - CPU valid/ready to multi-slave APB bridge with timeout
//
// Purpose : accepts one CPU request at a time, runs an APB SETUP/ACCESS
//           sequence to the decoded slave and returns a one-cycle MDONE with
//           read data and error status. Unmapped addresses and stalled slaves
//           complete with MSLVERR.
// Ports   : PCLK, PRESET                       clock, async active-high reset
//           MVALID/MREADY, MWRITE, MADDR,
//           MWDATA, MSTRB, MPROT               CPU request
//           MDONE, MRDATA, MSLVERR             CPU response
//           PSEL, PENABLE, PWRITE, PADDR,
//           PWDATA, PPROT, PSTRB               APB request
//           PRDATA, PREADY, PSLVERR            APB per-slave response
module apb_multi_slave_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int PROT_SIZE      = 3,
  parameter int STRB_SIZE      = DATA_SIZE / 8,
  parameter int NUM_SLAVES     = 4,
  parameter int REGION_BITS    = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             MVALID,
  output logic                             MREADY,
  input  logic                             MWRITE,
  input  logic [ADDR_SIZE-1:0]             MADDR,
  input  logic [DATA_SIZE-1:0]             MWDATA,
  input  logic [STRB_SIZE-1:0]             MSTRB,
  input  logic [PROT_SIZE-1:0]             MPROT,
  output logic                             MDONE,
  output logic [DATA_SIZE-1:0]             MRDATA,
  output logic                             MSLVERR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_SIZE-1:0]             PADDR,
  output logic [DATA_SIZE-1:0]             PWDATA,
  output logic [PROT_SIZE-1:0]             PPROT,
  output logic [STRB_SIZE-1:0]             PSTRB,
  input  logic [NUM_SLAVES*DATA_SIZE-1:0]  PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_valid;
  logic                 accept;
  logic [CNT_W-1:0]     cnt;
  logic                 timeout_hit;
  logic                 pready_sel;
  logic                 pslverr_sel;
  logic [DATA_SIZE-1:0] prdata_sel;

  apb_addr_decoder #(
    .ADDR_SIZE  (ADDR_SIZE),
    .NUM_SLAVES (NUM_SLAVES),
    .REGION_BITS(REGION_BITS),
    .IDX_W      (IDX_W)
  ) u_dec (
    .MADDR    (MADDR),
    .idx      (dec_idx),
    .idx_valid(dec_valid)
  );

  assign accept = MVALID && MREADY;

  // Only the registered index steers the response mux, so other slaves'
  // PREADY/PSLVERR/PRDATA have no effect.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
        prdata_sel  = PRDATA[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // cnt counts completed ACCESS cycles, so it equals TIMEOUT_CYCLES-1 during
  // the last permitted ACCESS cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    MREADY     = 1'b0;
    PENABLE    = 1'b0;
    PSEL       = '0;
    case (state)
      IDLE: begin
        MREADY = 1'b1;
        if (accept && dec_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        PENABLE = 1'b1;
        if (pready_sel || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (state != IDLE) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        PSEL[i] = (idx_q == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_q   <= '0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PPROT   <= '0;
      PSTRB   <= '0;
      cnt     <= '0;
      MDONE   <= 1'b0;
      MRDATA  <= '0;
      MSLVERR <= 1'b0;
    end else begin
      MDONE <= 1'b0;

      if (accept) begin
        if (dec_valid) begin
          idx_q  <= dec_idx;
          PWRITE <= MWRITE;
          PADDR  <= MADDR;
          PWDATA <= MWDATA;
          PPROT  <= MPROT;
          PSTRB  <= MWRITE ? MSTRB : '0;
        end else begin
          // Unmapped address: answer immediately, the APB bus stays idle.
          MDONE   <= 1'b1;
          MSLVERR <= 1'b1;
          MRDATA  <= '0;
        end
      end

      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + CNT_W'(1);
      end

      // PREADY is checked first so a slave answering in the last allowed
      // cycle still returns its own response.
      if (state == ACCESS) begin
        if (pready_sel) begin
          MDONE   <= 1'b1;
          MSLVERR <= pslverr_sel;
          MRDATA  <= PWRITE ? '0 : prdata_sel;
        end else if (timeout_hit) begin
          MDONE   <= 1'b1;
          MSLVERR <= 1'b1;
          MRDATA  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// tb/tb_apb_multi_slave_bridge.sv - directed self-checking bench for apb_multi_slave_bridge
module tb_apb_multi_slave_bridge;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic         MVALID;
  logic         MREADY;
  logic         MWRITE;
  logic [31:0]  MADDR;
  logic [31:0]  MWDATA;
  logic [3:0]   MSTRB;
  logic [2:0]   MPROT;
  logic         MDONE;
  logic [31:0]  MRDATA;
  logic         MSLVERR;
  logic [3:0]   PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PADDR;
  logic [31:0]  PWDATA;
  logic [2:0]   PPROT;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;
  logic [3:0]   PSLVERR;

  int tests = 0;
  int fails = 0;

  apb_multi_slave_bridge #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .PROT_SIZE(3), .STRB_SIZE(4),
    .NUM_SLAVES(4), .REGION_BITS(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .MVALID(MVALID), .MREADY(MREADY), .MWRITE(MWRITE), .MADDR(MADDR),
    .MWDATA(MWDATA), .MSTRB(MSTRB), .MPROT(MPROT),
    .MDONE(MDONE), .MRDATA(MRDATA), .MSLVERR(MSLVERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PPROT(PPROT), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;      // PREADY-low ACCESS cycles before the slave answers
    logic [31:0] rdata_in;
    logic        err_in;
    logic [3:0]  exp_psel;   // 0 = decode error
    int          exp_access; // ACCESS cycles expected
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Selected slave gets the vector's data; every other slave is ready, erroring
  // and returning junk, all of which the bridge must ignore.
  task automatic set_slaves(input int sel, input logic [31:0] rd, input logic err,
                            input logic rdy);
    for (int i = 0; i < 4; i++) begin
      if (i == sel) begin
        PRDATA[i*32 +: 32] = rd;
        PSLVERR[i]         = err;
        PREADY[i]          = rdy;
      end else begin
        PRDATA[i*32 +: 32] = 32'hBAD0_0000 | i;
        PSLVERR[i]         = 1'b1;
        PREADY[i]          = 1'b1;
      end
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int sel;
    logic [3:0] exp_strb;
    sel      = (v.exp_psel == 4'b0) ? -1 : int'(v.addr[13:12]);
    exp_strb = v.wr ? v.strb : 4'b0;
    set_slaves(sel, v.rdata_in, v.err_in, 1'b0);
    MWRITE = v.wr; MADDR = v.addr; MWDATA = v.wdata; MSTRB = v.strb; MPROT = v.prot;
    MVALID = 1'b1;
    check($sformatf("v%0d_mready_idle", n), MREADY, 1'b1);
    tick();
    MVALID = 1'b0;
    if (v.exp_access == 0) begin
      check($sformatf("v%0d_decerr_mdone", n), MDONE, 1'b1);
      check($sformatf("v%0d_decerr_psel", n), PSEL, 4'b0);
      check($sformatf("v%0d_decerr_mready", n), MREADY, 1'b1);
    end else begin
      check($sformatf("v%0d_setup_psel", n), PSEL, v.exp_psel);
      check($sformatf("v%0d_setup_penable", n), PENABLE, 1'b0);
      check($sformatf("v%0d_setup_mready", n), MREADY, 1'b0);
      check($sformatf("v%0d_paddr", n), PADDR, v.addr);
      check($sformatf("v%0d_pwrite", n), PWRITE, v.wr);
      check($sformatf("v%0d_pwdata", n), PWDATA, v.wdata);
      check($sformatf("v%0d_pprot", n), PPROT, v.prot);
      check($sformatf("v%0d_pstrb", n), PSTRB, exp_strb);
      tick();
      for (int c = 0; c < v.exp_access; c++) begin
        check($sformatf("v%0d_acc%0d_penable", n, c), PENABLE, 1'b1);
        check($sformatf("v%0d_acc%0d_psel", n, c), PSEL, v.exp_psel);
        check($sformatf("v%0d_acc%0d_paddr", n, c), PADDR, v.addr);
        check($sformatf("v%0d_acc%0d_mdone", n, c), MDONE, 1'b0);
        PREADY[sel] = (c == v.waits);
        tick();
      end
      check($sformatf("v%0d_done_mdone", n), MDONE, 1'b1);
      check($sformatf("v%0d_done_psel", n), PSEL, 4'b0);
      check($sformatf("v%0d_done_penable", n), PENABLE, 1'b0);
      check($sformatf("v%0d_done_mready", n), MREADY, 1'b1);
    end
    check($sformatf("v%0d_mrdata", n), MRDATA, v.exp_rdata);
    check($sformatf("v%0d_mslverr", n), MSLVERR, v.exp_err);
    set_slaves(-1, 32'h0, 1'b0, 1'b1);
    tick();
    check($sformatf("v%0d_mdone_pulse", n), MDONE, 1'b0);
    check($sformatf("v%0d_mrdata_hold", n), MRDATA, v.exp_rdata);
    check($sformatf("v%0d_mslverr_hold", n), MSLVERR, v.exp_err);
  endtask

  initial begin
    //          wr    addr          wdata         strb     prot  waits rdata_in      err   psel     acc rdata         err
    vecs[0] = '{1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 4'b0011, 3'd2, 0,    32'h5555_5555, 1'b0, 4'b0100, 1,  32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h0000_1004, 32'h1111_2222, 4'b1111, 3'd0, 3,    32'h1234_5678, 1'b0, 4'b0010, 4,  32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_5000, 32'h0,         4'b0000, 3'd1, 0,    32'h0,         1'b0, 4'b0000, 0,  32'h0,        1'b1};
    vecs[3] = '{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 3'd0, 1000, 32'h7777_7777, 1'b0, 4'b0001, 16, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'b0000, 3'd5, 0,    32'hA5A5_A5A5, 1'b1, 4'b1000, 1,  32'hA5A5_A5A5, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 3'd7, 15,   32'hCAFE_F00D, 1'b0, 4'b0001, 16, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_3000, 32'h0102_0304, 4'b1100, 3'd3, 2,    32'h9999_9999, 1'b1, 4'b1000, 3,  32'h0,        1'b1};

    PRESET = 1'b1;
    MVALID = 1'b0; MWRITE = 1'b0; MADDR = '0; MWDATA = '0; MSTRB = '0; MPROT = '0;
    set_slaves(-1, 32'h0, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_mready", MREADY, 1'b1);
    check("rst_mdone", MDONE, 1'b0);
    check("rst_mrdata", MRDATA, 32'h0);
    check("rst_mslverr", MSLVERR, 1'b0);
    check("rst_psel", PSEL, 4'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pprot", PPROT, 3'h0);
    check("rst_pstrb", PSTRB, 4'h0);
    PRESET = 1'b0;
    tick();

    for (int n = 0; n < 7; n++) begin
      run_vec(n, vecs[n]);
    end

    // Back-to-back decode errors with MVALID held: one MDONE per cycle.
    MWRITE = 1'b0; MADDR = 32'h0000_4000; MVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("decerr_b2b%0d_mdone", k), MDONE, 1'b1);
      check($sformatf("decerr_b2b%0d_mslverr", k), MSLVERR, 1'b1);
      check($sformatf("decerr_b2b%0d_mready", k), MREADY, 1'b1);
      check($sformatf("decerr_b2b%0d_psel", k), PSEL, 4'b0);
    end
    MVALID = 1'b0;
    tick();
    check("decerr_b2b_end_mdone", MDONE, 1'b0);

    // Reset pulsed asynchronously in the middle of an ACCESS phase.
    set_slaves(1, 32'h4444_4444, 1'b0, 1'b0);
    MWRITE = 1'b1; MADDR = 32'h0000_1020; MWDATA = 32'h8888_8888; MSTRB = 4'hF;
    MPROT = 3'd6; MVALID = 1'b1;
    tick();
    MVALID = 1'b0;
    tick();
    check("abort_in_access", PENABLE, 1'b1);
    #3;
    PRESET = 1'b1;
    #1;
    check("abort_psel", PSEL, 4'b0);
    check("abort_penable", PENABLE, 1'b0);
    check("abort_mready", MREADY, 1'b1);
    check("abort_paddr", PADDR, 32'h0);
    check("abort_pwdata", PWDATA, 32'h0);
    check("abort_pstrb", PSTRB, 4'h0);
    check("abort_pprot", PPROT, 3'h0);
    check("abort_pwrite", PWRITE, 1'b0);
    check("abort_mdone", MDONE, 1'b0);
    tick();
    PRESET = 1'b0;
    PREADY[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("abort_no_mdone%0d", k), MDONE, 1'b0);
    end

    // Back-to-back reads to slaves 0 and 3 with MVALID held high.
    PREADY = 4'hF; PSLVERR = 4'h0;
    PRDATA[0*32 +: 32] = 32'h00C0_FFEE;
    PRDATA[3*32 +: 32] = 32'h3333_3333;
    MWRITE = 1'b0; MADDR = 32'h0000_0000; MVALID = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) MADDR = 32'h0000_3000;
      check($sformatf("b2b_c%0d_mdone", n), MDONE, (n == 3 || n == 6));
      if (n == 1) check("b2b_first_psel", PSEL, 4'b0001);
      if (n == 3) check("b2b_first_rdata", MRDATA, 32'h00C0_FFEE);
      if (n == 4) check("b2b_second_psel", PSEL, 4'b1000);
      if (n == 6) begin
        check("b2b_second_rdata", MRDATA, 32'h3333_3333);
        check("b2b_second_err", MSLVERR, 1'b0);
        MVALID = 1'b0;
      end
    end
    check("b2b_idle_psel", PSEL, 4'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_multi_slave_bridge.md
# apb_multi_slave_bridge

Parametrised APB bridge that accepts CPU transfer requests over a valid/ready handshake and runs APB SETUP/ACCESS sequences to one of NUM_SLAVES peripherals. Each peripheral is selected by address decode. The bridge adds per-transfer completion signalling, decode-error responses and a wait-state timeout. It replaces the single-slave, change-detect bridge between the CPU port and the peripheral bus.

## Interface
- ADDR_SIZE, 32, address width
- DATA_SIZE, 32, data width (multiple of 8)
- PROT_SIZE, 3, PPROT width
- STRB_SIZE, DATA_SIZE/8, write-strobe width
- NUM_SLAVES, 4, number of APB slaves (1..16)
- REGION_BITS, 12, log2 of per-slave address window; slave index = MADDR[REGION_BITS +: IDX_W], IDX_W = max(1, clog2(NUM_SLAVES))
- TIMEOUT_CYCLES, 16, max ACCESS cycles before forced error; 0 disables timeout
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset; one clock; reset is asynchronous and active-high
- MVALID  in  1  CPU request valid
- MREADY  out  1  bridge can accept request
- MWRITE  in  1  1=write, 0=read
- MADDR  in  ADDR_SIZE  request address
- MWDATA  in  DATA_SIZE  write data
- MSTRB  in  STRB_SIZE  write strobes
- MPROT  in  PROT_SIZE  protection attributes
- MDONE  out  1  one-cycle completion pulse
- MRDATA  out  DATA_SIZE  read data, valid with MDONE
- MSLVERR  out  1  error response, valid with MDONE
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  access phase
- PWRITE, PADDR, PWDATA, PPROT, PSTRB  out  per parameters  registered transfer attributes
- PRDATA  in  NUM_SLAVES*DATA_SIZE  slave i read data at [i*DATA_SIZE +: DATA_SIZE]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

## Operation
- States: IDLE, SETUP, ACCESS. MREADY = (state == IDLE). Requests are accepted on a rising edge with MVALID & MREADY.
- **Accept with valid index (idx < NUM_SLAVES):**
  - Register MWRITE, MADDR, MWDATA, MPROT and idx.
  - Register PSTRB = MWRITE ? MSTRB : 0.
  - Go to SETUP.
- **Accept with invalid index (idx ≥ NUM_SLAVES):**
  - No APB activity; state stays IDLE.
  - Next cycle: MDONE=1, MSLVERR=1, MRDATA=0.
- **SETUP:** PSEL[idx]=1, PENABLE=0. Always go to ACCESS.
- **ACCESS:** PSEL[idx]=1, PENABLE=1. The timeout counter increments each ACCESS cycle.
  - PREADY[idx]=1: go to IDLE. Next cycle: MDONE=1, MSLVERR=PSLVERR[idx], MRDATA=PRDATA[idx] for reads, 0 for writes.
  - Else, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES: go to IDLE. Next cycle: MDONE=1, MSLVERR=1, MRDATA=0.
  - PREADY wins over timeout when both occur in the same cycle.
- PREADY, PSLVERR and PRDATA of unselected slaves are ignored. PSLVERR is sampled only when PREADY[idx]=1.
- PADDR, PWRITE, PWDATA, PPROT and PSTRB hold stable from SETUP until the next accept.
- MRDATA and MSLVERR hold their value until the next MDONE.

## Timing
- Reset values:
  - state IDLE, MREADY=1, MDONE=0, MRDATA=0, MSLVERR=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PPROT=0, PSTRB=0.
  - Timeout counter 0.
- Zero-wait transfer: accept at edge k; SETUP in cycle k+1; ACCESS in cycle k+2; MDONE and MREADY high in cycle k+3. A new request may be accepted at the end of cycle k+3.
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- Decode error: MDONE is high in the cycle after accept. MREADY stays high, so back-to-back accepts are allowed.
- No combinational path from any input to any output. PSEL, PENABLE and MREADY decode only from registered state and index.
- Counter width: clog2(TIMEOUT_CYCLES+1). The counter clears on entering ACCESS.
- PRESET asserted mid-transfer: all outputs go to reset values immediately. No MDONE is issued for the aborted transfer.

## Structure
- Shared package apb_bridge_pkg holds:
  - state encodings IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10;
  - the slave-index width function.
- One sub-module, apb_addr_decoder (combinational):
  - inputs: MADDR;
  - outputs: idx and idx_valid;
  - parameters: NUM_SLAVES, REGION_BITS.
- The top level holds the FSM, transfer registers, timeout counter and response registers.

## Test plan
- Write to slave 2 (MADDR=0x2010, MWDATA=0xDEADBEEF, MSTRB=4'b0011), PREADY tied high -> PSEL=4'b0100 for 2 cycles, PENABLE in the second only, PSTRB=4'b0011; MDONE 3 cycles after accept, MSLVERR=0.
- Read from slave 1 with 3 wait states, PRDATA[1]=0x12345678 -> ACCESS lasts 4 cycles; MDONE with MRDATA=0x12345678; PADDR stable throughout.
- Read to MADDR=0x5000 with NUM_SLAVES=4 -> no PSEL; MDONE next cycle, MSLVERR=1, MRDATA=0.
- Slave 0 holds PREADY low, TIMEOUT_CYCLES=16 -> PSEL/PENABLE drop after 16 ACCESS cycles; MDONE with MSLVERR=1.
- PRESET pulsed during ACCESS; then back-to-back reads to slaves 0 and 3 with MVALID held high -> outputs reset asynchronously, no MDONE for the aborted transfer; then two MDONE pulses 3 cycles apart, each with correct PRDATA.
